forward_ctrl: RTL and testbench

FORWARD_CTRL -- requirements
Module: forward_ctrl

---
 rtl/forward_ctrl_pkg.sv | 40 ++++
 rtl/forward_ctrl_operand_sel.sv | 27 ++
 rtl/forward_ctrl.sv | 106 ++++++++++
 tb/tb_forward_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/forward_ctrl_pkg.sv
// Shared types for the forwarding/hazard controller: operand-select encodings,
// controller state and the per-stage pipeline slot record.
package forward_ctrl_pkg;

  // Slot address fields are sized for the widest register file supported; the
  // top zero-extends its REG_AW-wide addresses into them.
  localparam int SLOT_AW = 8;

  localparam logic [2:0] FWD_RF  = 3'b000;
  localparam logic [2:0] FWD_MEM = 3'b001;
  localparam logic [2:0] FWD_WB  = 3'b010;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } fsm_state_e;

  typedef struct packed {
    logic               valid;
    logic [SLOT_AW-1:0] rs1;
    logic [SLOT_AW-1:0] rs2;
    logic               use_rs1;
    logic               use_rs2;
    logic [SLOT_AW-1:0] rd;
    logic               reg_write;
    logic               mem_read;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '0;

  // r0 is hardwired, so a write to it never produces a forwardable value.
  function automatic logic is_fwd_src(input slot_t s);
    return s.valid && s.reg_write && (s.rd != '0);
  endfunction

  function automatic logic writes_reg(input slot_t s, input logic [SLOT_AW-1:0] r);
    return is_fwd_src(s) && (s.rd == r);
  endfunction

endpackage

// File: rtl/forward_ctrl_operand_sel.sv
// Per-operand forwarding priority: the younger MEM result wins over WB, but a
// load still in MEM has no data yet and is skipped.
module fwd_operand_sel
  import forward_ctrl_pkg::*;
#(
  parameter int SEL_W = 3
) (
  input  logic                ex_valid_i,
  input  logic                use_i,
  input  logic [SLOT_AW-1:0]  rs_i,
  input  slot_t               mem_slot_i,
  input  slot_t               wb_slot_i,
  output logic [SEL_W-1:0]    sel_o
);

  always_comb begin
    sel_o = SEL_W'(FWD_RF);
    if (ex_valid_i && use_i) begin
      if (writes_reg(mem_slot_i, rs_i) && !mem_slot_i.mem_read) begin
        sel_o = SEL_W'(FWD_MEM);
      end else if (writes_reg(wb_slot_i, rs_i)) begin
        sel_o = SEL_W'(FWD_WB);
      end
    end
  end

endmodule

// File: rtl/forward_ctrl.sv
// Operand-forwarding and load-use stall controller for a 5-stage pipeline.
// Tracks the EX/MEM/WB instructions and steers the EX operand muxes.
module forward_ctrl
  import forward_ctrl_pkg::*;
#(
  parameter int REG_AW = 4,
  parameter int SEL_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_use_rs1_i,
  input  logic              id_use_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_reg_write_i,
  input  logic              id_mem_read_i,
  input  logic              flush_i,
  input  logic              mem_wait_i,
  output logic [SEL_W-1:0]  fwd_sel_a_o,
  output logic [SEL_W-1:0]  fwd_sel_b_o,
  output logic              stall_o,
  output fsm_state_e        state_o
);

  slot_t      ex_q, mem_q, wb_q;
  slot_t      ex_d, mem_d, wb_d;
  slot_t      id_slot;
  fsm_state_e state_q, state_d;
  logic       load_use;
  logic       hazard_stall;

  always_comb begin
    id_slot           = SLOT_EMPTY;
    id_slot.valid     = id_valid_i;
    id_slot.rs1       = SLOT_AW'(id_rs1_i);
    id_slot.rs2       = SLOT_AW'(id_rs2_i);
    id_slot.use_rs1   = id_use_rs1_i;
    id_slot.use_rs2   = id_use_rs2_i;
    id_slot.rd        = SLOT_AW'(id_rd_i);
    id_slot.reg_write = id_reg_write_i;
    id_slot.mem_read  = id_mem_read_i;
  end

  // A load in EX cannot be forwarded to the instruction right behind it.
  assign load_use = id_valid_i && is_fwd_src(ex_q) && ex_q.mem_read &&
                    ((id_use_rs1_i && (ex_q.rd == id_slot.rs1)) ||
                     (id_use_rs2_i && (ex_q.rd == id_slot.rs2)));

  assign hazard_stall = (state_q == ST_RUN) && load_use && !flush_i;

  // mem_wait is gated by rst_n so a held mem_wait cannot stall a core in reset.
  assign stall_o = (mem_wait_i && rst_n) || hazard_stall;
  assign state_o = state_q;

  always_comb begin
    ex_d    = ex_q;
    mem_d   = mem_q;
    wb_d    = wb_q;
    state_d = state_q;
    if (!mem_wait_i) begin
      mem_d   = ex_q;
      wb_d    = mem_q;
      state_d = hazard_stall ? ST_STALL : ST_RUN;
      if (flush_i || hazard_stall || !id_valid_i) begin
        ex_d = SLOT_EMPTY;
      end else begin
        ex_d = id_slot;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= SLOT_EMPTY;
      mem_q   <= SLOT_EMPTY;
      wb_q    <= SLOT_EMPTY;
      state_q <= ST_RUN;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      state_q <= state_d;
    end
  end

  fwd_operand_sel #(.SEL_W(SEL_W)) u_sel_a (
    .ex_valid_i (ex_q.valid),
    .use_i      (ex_q.use_rs1),
    .rs_i       (ex_q.rs1),
    .mem_slot_i (mem_q),
    .wb_slot_i  (wb_q),
    .sel_o      (fwd_sel_a_o)
  );

  fwd_operand_sel #(.SEL_W(SEL_W)) u_sel_b (
    .ex_valid_i (ex_q.valid),
    .use_i      (ex_q.use_rs2),
    .rs_i       (ex_q.rs2),
    .mem_slot_i (mem_q),
    .wb_slot_i  (wb_q),
    .sel_o      (fwd_sel_b_o)
  );

endmodule

// File: tb/tb_forward_ctrl.sv
// Bench for forward_ctrl: directed vector table, hand-built reset sequence and
// randomized instruction streams checked against a stage-array reference model.
module tb_forward_ctrl;
  import forward_ctrl_pkg::*;

  typedef struct packed {
    logic       v;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic       u1;
    logic       u2;
    logic [3:0] rd;
    logic       rw;
    logic       mr;
  } instr_t;

  typedef struct {
    string      name;
    instr_t     ins;
    logic       fl;
    logic       mw;
    logic [7:0] exp;
  } vec_t;

  localparam instr_t NOP = '0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
  logic [3:0] id_rs1, id_rs2, id_rd;
  logic       flush, mem_wait;
  logic [2:0] fwd_sel_a, fwd_sel_b;
  logic       stall;
  fsm_state_e state;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];

  // Reference pipeline: index 0 = EX, 1 = MEM, 2 = WB (program order oldest last).
  instr_t     pipe[3];
  logic       just_stalled;

  forward_ctrl #(.REG_AW(4), .SEL_W(3)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_valid_i     (id_valid),
    .id_rs1_i       (id_rs1),
    .id_rs2_i       (id_rs2),
    .id_use_rs1_i   (id_use_rs1),
    .id_use_rs2_i   (id_use_rs2),
    .id_rd_i        (id_rd),
    .id_reg_write_i (id_reg_write),
    .id_mem_read_i  (id_mem_read),
    .flush_i        (flush),
    .mem_wait_i     (mem_wait),
    .fwd_sel_a_o    (fwd_sel_a),
    .fwd_sel_b_o    (fwd_sel_b),
    .stall_o        (stall),
    .state_o        (state)
  );

  always #5 clk = ~clk;

  task automatic drive(input instr_t i, input logic fl, input logic mw);
    id_valid     = i.v;
    id_rs1       = i.rs1;
    id_rs2       = i.rs2;
    id_use_rs1   = i.u1;
    id_use_rs2   = i.u2;
    id_rd        = i.rd;
    id_reg_write = i.rw;
    id_mem_read  = i.mr;
    flush        = fl;
    mem_wait     = mw;
  endtask

  task automatic check(input string nm);
    logic [7:0] act;
    logic [7:0] exp;
    exp = exp_q.pop_front();
    act = {stall, (state == ST_STALL), fwd_sel_a, fwd_sel_b};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got stall=%0b st=%0b a=%03b b=%03b, want stall=%0b st=%0b a=%03b b=%03b",
               nm, act[7], act[6], act[5:3], act[2:0], exp[7], exp[6], exp[5:3], exp[2:0]);
    end
  endtask

  function automatic vec_t mkv(input string nm, input logic v, input int rd, input int rs1,
                               input int rs2, input logic u1, input logic u2, input logic rw,
                               input logic mr, input logic fl, input logic mw, input logic es,
                               input logic est, input logic [2:0] ea, input logic [2:0] eb);
    vec_t r;
    r.name = nm;
    r.ins  = '{v: v, rs1: 4'(rs1), rs2: 4'(rs2), u1: u1, u2: u2, rd: 4'(rd), rw: rw, mr: mr};
    r.fl   = fl;
    r.mw   = mw;
    r.exp  = {es, est, ea, eb};
    return r;
  endfunction

  task automatic apply_vec(input vec_t t);
    drive(t.ins, t.fl, t.mw);
    exp_q.push_back(t.exp);
    @(negedge clk);
    check(t.name);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(NOP, 1'b0, 1'b1);
    #2;
    exp_q.push_back(8'h00);
    check("reset_state");
    repeat (2) @(posedge clk);
    #1;
    mem_wait = 1'b0;
    rst_n = 1'b1;
  endtask

  function automatic logic produces(input instr_t s, input logic [3:0] r);
    return s.v && s.rw && (s.rd != 4'd0) && (s.rd == r);
  endfunction

  function automatic logic [2:0] model_sel(input logic [3:0] r, input logic u);
    if (!pipe[0].v || !u) return FWD_RF;
    if (produces(pipe[1], r) && !pipe[1].mr) return FWD_MEM;
    if (produces(pipe[2], r)) return FWD_WB;
    return FWD_RF;
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    i.v   = ($urandom_range(0, 3) != 0);
    i.rs1 = 4'($urandom_range(0, 3));
    i.rs2 = 4'($urandom_range(0, 3));
    i.u1  = 1'($urandom_range(0, 1));
    i.u2  = 1'($urandom_range(0, 1));
    i.rd  = 4'($urandom_range(0, 3));
    i.rw  = ($urandom_range(0, 4) != 0);
    i.mr  = i.rw && ($urandom_range(0, 2) == 0);
    return i;
  endfunction

  initial begin
    vec_t   tbl[$];
    instr_t cur;
    logic   fl, mw, hold, lu, hz, exp_stall;

    do_reset();

    // Directed sequences: forward from MEM, from WB, load-use, r0, flush, mem_wait.
    tbl.push_back(mkv("add_r3",        1, 3, 1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 3'd0, 3'd0));
    tbl.push_back(mkv("use_r3_rs1",    1, 4, 3, 1, 1, 1, 1, 0, 0, 0, 0, 0, 3'd0, 3'd0));
    tbl.push_back(mkv("fwd_mem_a",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd1, 3'd0));
    tbl.push_back(mkv("add_r7",        1, 7, 1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 3'd0, 3'd0));
    tbl.push_back(mkv("independent",   1, 8, 9, 10, 1, 1, 1, 0, 0, 0, 0, 0, 3'd0, 3'd0));
    tbl.push_back(mkv("use_r7_rs2",    1, 9, 2, 7, 1, 1, 1, 0, 0, 0, 0, 0, 3'd0, 3'd0));
    tbl.push_back(mkv("fwd_wb_b",      1, 5, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 3'd0, 3'd2));
    tbl.push_back(mkv("load_use",      1, 6, 5, 2, 1, 1, 1, 0, 0, 0, 1, 0, 3'd0, 3'd0));
    tbl.push_back(mkv("stall_once",    1, 6, 5, 2, 1, 1, 1, 0, 0, 0, 0, 1, 3'd0, 3'd0));
    tbl.push_back(mkv("fwd_wb_load",   1, 0, 1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 3'd2, 3'd0));
    tbl.push_back(mkv("read_r0",       1, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 3'd0, 3'd0));
    tbl.push_back(mkv("r0_no_fwd",     1, 5, 2, 0, 1, 0, 1, 1, 0, 0, 0, 0, 3'd0, 3'd0));
    tbl.push_back(mkv("flush_hazard",  1, 6, 5, 2, 1, 1, 1, 0, 1, 0, 0, 0, 3'd0, 3'd0));
    tbl.push_back(mkv("after_flush",   1, 2, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 3'd0, 3'd0));
    tbl.push_back(mkv("add_r3_b",      1, 3, 2, 1, 1, 1, 1, 0, 0, 0, 0, 0, 3'd0, 3'd0));
    tbl.push_back(mkv("memwait_1",     1, 4, 3, 3, 1, 1, 1, 0, 0, 1, 1, 0, 3'd1, 3'd0));
    tbl.push_back(mkv("memwait_2",     1, 4, 3, 3, 1, 1, 1, 0, 0, 1, 1, 0, 3'd1, 3'd0));
    tbl.push_back(mkv("memwait_3",     1, 4, 3, 3, 1, 1, 1, 0, 0, 1, 1, 0, 3'd1, 3'd0));
    tbl.push_back(mkv("memwait_rel",   1, 4, 3, 3, 1, 1, 1, 0, 0, 0, 0, 0, 3'd1, 3'd0));
    tbl.push_back(mkv("resume_fwd",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd1, 3'd1));
    foreach (tbl[i]) apply_vec(tbl[i]);

    // Reset asserted while stalled and frozen by mem_wait.
    do_reset();
    apply_vec(mkv("rs_add_r3",     1, 3, 1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 3'd0, 3'd0));
    apply_vec(mkv("rs_load_r5",    1, 5, 3, 0, 1, 0, 1, 1, 0, 0, 0, 0, 3'd0, 3'd0));
    apply_vec(mkv("rs_load_use",   1, 6, 5, 0, 1, 0, 1, 0, 0, 0, 1, 0, 3'd1, 3'd0));
    drive('{v: 1, rs1: 4'd5, rs2: 4'd0, u1: 1, u2: 0, rd: 4'd6, rw: 1, mr: 0}, 1'b0, 1'b1);
    exp_q.push_back(8'b1100_0000);
    @(negedge clk);
    check("rs_stall_frozen");
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(8'h00);
    check("rs_async_clear");
    @(posedge clk);
    #1;
    exp_q.push_back(8'h00);
    check("rs_held");
    mem_wait = 1'b0;
    rst_n = 1'b1;
    apply_vec(mkv("post_add_r3",   1, 3, 1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 3'd0, 3'd0));
    apply_vec(mkv("post_use_r3",   1, 4, 3, 1, 1, 1, 1, 0, 0, 0, 0, 0, 3'd0, 3'd0));
    apply_vec(mkv("post_fwd_mem",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd1, 3'd0));

    // Randomized streams against the reference model.
    do_reset();
    foreach (pipe[i]) pipe[i] = NOP;
    just_stalled = 1'b0;
    hold = 1'b0;
    cur = NOP;
    for (int n = 0; n < 400; n++) begin
      if (!hold) cur = rand_instr();
      fl = ($urandom_range(0, 7) == 0);
      mw = ($urandom_range(0, 5) == 0);
      drive(cur, fl, mw);
      lu = cur.v && pipe[0].v && pipe[0].mr &&
           ((cur.u1 && produces(pipe[0], cur.rs1)) || (cur.u2 && produces(pipe[0], cur.rs2)));
      hz = !just_stalled && lu && !fl;
      exp_stall = mw || hz;
      exp_q.push_back({exp_stall, just_stalled, model_sel(pipe[0].rs1, pipe[0].u1),
                       model_sel(pipe[0].rs2, pipe[0].u2)});
      @(negedge clk);
      check("random");
      if (!mw) begin
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = (fl || hz || !cur.v) ? NOP : cur;
        just_stalled = hz;
      end
      hold = exp_stall && !(fl && !mw);
      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
